// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg
// Shared definitions for the clock time-set controller: the controller state
// encoding, the field_sel codes seen by the hh:mm:ss datapath and display mux,
// and small helpers that map states to the mode-button sequence and to fields.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_t;

   localparam logic [1:0] FLD_HR   = 2'b00;
   localparam logic [1:0] FLD_MIN  = 2'b01;
   localparam logic [1:0] FLD_SEC  = 2'b10;
   localparam logic [1:0] FLD_NONE = 2'b11;

   // Mode button walks RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
   function automatic state_t next_mode_state(input state_t s);
      state_t n;
      case (s)
         ST_RUN:     n = ST_SET_HR;
         ST_SET_HR:  n = ST_SET_MIN;
         ST_SET_MIN: n = ST_SET_SEC;
         default:    n = ST_RUN;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] state_to_field(input state_t s);
      logic [1:0] f;
      case (s)
         ST_SET_HR:  f = FLD_HR;
         ST_SET_MIN: f = FLD_MIN;
         ST_SET_SEC: f = FLD_SEC;
         default:    f = FLD_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/btn_sampler.sv
// btn_sampler
// Tick-gated two-flop sampler for one push-button with press detection and
// hold-to-repeat timing. All events are produced only in the clk_i cycle that
// follows a tick, so they line up with the controller's tick-delayed logic.
//
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   tick_i    one-cycle slow tick enable
//   btn_i     raw button level
//   press_o   one-cycle press event (s1 & ~s2, cycle after tick)
//   repeat_o  one-cycle auto-repeat event while the button stays held
//   held_o    sampled button level (s1)
module btn_sampler
   import clock_ctrl_pkg::*;
#(
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic btn_i,
   output logic press_o,
   output logic repeat_o,
   output logic held_o
);

   localparam int HOLD_MAX = REPEAT_DELAY + REPEAT_RATE;
   localparam int HW       = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] DELAY_C = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] MAX_C   = HW'(HOLD_MAX);

   logic          s1_q, s2_q;
   logic          eval_q;
   logic [HW-1:0] hold_q, hold_d;
   logic [HW-1:0] hold_step;
   logic          rep_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         eval_q <= 1'b0;
         hold_q <= '0;
      end else begin
         eval_q <= tick_i;
         if (tick_i) begin
            s1_q <= btn_i;
            s2_q <= s1_q;
         end
         hold_q <= hold_d;
      end
   end

   // hold_q never rests above HOLD_MAX-1, so the step cannot overflow.
   assign hold_step = hold_q + 1'b1;

   always_comb begin
      hold_d = hold_q;
      rep_d  = 1'b0;
      if (eval_q) begin
         if (!s1_q || !s2_q) begin
            // Released, or the press tick itself: count restarts at 0.
            hold_d = '0;
         end else if (hold_step == MAX_C) begin
            rep_d  = 1'b1;
            hold_d = DELAY_C;
         end else begin
            rep_d  = (hold_step == DELAY_C);
            hold_d = hold_step;
         end
      end
   end

   assign press_o  = eval_q & s1_q & ~s2_q;
   assign repeat_o = rep_d;
   assign held_o   = s1_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Time-set controller for the digital clock. Three button samplers feed a
// RUN/SET_HR/SET_MIN/SET_SEC state machine that issues single-cycle adjust
// pulses to the hh:mm:ss counters, a field select and blink flag for the
// display mux, and a run enable that freezes time while setting.
//
// Ports:
//   clk_in      system clock
//   reset       asynchronous active-high reset
//   tick_in     one-cycle slow tick enable
//   btn_mode    mode button level
//   btn_up      up button level
//   btn_down    down button level
//   run_en      timekeeping counters may advance (RUN only)
//   field_sel   00 hr, 01 min, 10 sec, 11 none
//   inc_pulse   increment selected field
//   dec_pulse   decrement selected field
//   clr_pulse   clear seconds
//   blink       blank the selected display field when high
//
// state      | meaning
// -----------+----------------------------------------------
// ST_RUN     | clock running, up/down ignored
// ST_SET_HR  | hours selected, up/down inc/dec with repeat
// ST_SET_MIN | minutes selected, up/down inc/dec with repeat
// ST_SET_SEC | seconds selected, up/down clears seconds
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10,
   parameter int IDLE_TIMEOUT = 1000,
   parameter int BLINK_TICKS  = 25
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       tick_in,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       run_en,
   output logic [1:0] field_sel,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       clr_pulse,
   output logic       blink
);

   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS);

   logic mode_press, mode_rep, mode_held;
   logic up_press, up_rep, up_held;
   logic dn_press, dn_rep, dn_held;
   logic unused_mode;

   btn_sampler #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_mode (
      .clk_i(clk_in), .rst_i(reset), .tick_i(tick_in), .btn_i(btn_mode),
      .press_o(mode_press), .repeat_o(mode_rep), .held_o(mode_held)
   );

   btn_sampler #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
      .clk_i(clk_in), .rst_i(reset), .tick_i(tick_in), .btn_i(btn_up),
      .press_o(up_press), .repeat_o(up_rep), .held_o(up_held)
   );

   btn_sampler #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
      .clk_i(clk_in), .rst_i(reset), .tick_i(tick_in), .btn_i(btn_down),
      .press_o(dn_press), .repeat_o(dn_rep), .held_o(dn_held)
   );

   // Mode never auto-repeats; holding it gives exactly one advance.
   assign unused_mode = mode_rep | mode_held;

   state_t        state_q, state_d;
   logic          tick_q;
   logic [IW-1:0] idle_q, idle_d, idle_step;
   logic [BW-1:0] bcnt_q, bcnt_d, bcnt_step;
   logic          blink_q, blink_d;
   logic          inc_q, inc_d;
   logic          dec_q, dec_d;
   logic          clr_q, clr_d;
   logic          run_en_q;
   logic [1:0]    fsel_q;

   logic both_held;
   logic up_ev, dn_ev;
   logic any_press;
   logic timeout;

   assign both_held = up_held & dn_held;
   assign up_ev     = up_press | (up_rep & ~both_held);
   assign dn_ev     = dn_press | (dn_rep & ~both_held);
   assign any_press = mode_press | up_press | dn_press;
   assign idle_step = idle_q + 1'b1;
   assign bcnt_step = bcnt_q + 1'b1;
   assign timeout   = tick_q && (state_q != ST_RUN) && !any_press
                      && (idle_step == IDLE_MAX);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q  <= ST_RUN;
         tick_q   <= 1'b0;
         idle_q   <= '0;
         bcnt_q   <= '0;
         blink_q  <= 1'b0;
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         clr_q    <= 1'b0;
         run_en_q <= 1'b1;
         fsel_q   <= FLD_NONE;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_in;
         idle_q   <= idle_d;
         bcnt_q   <= bcnt_d;
         blink_q  <= blink_d;
         inc_q    <= inc_d;
         dec_q    <= dec_d;
         clr_q    <= clr_d;
         run_en_q <= (state_d == ST_RUN);
         fsel_q   <= state_to_field(state_d);
      end
   end

   always_comb begin
      state_d = state_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      clr_d   = 1'b0;
      idle_d  = idle_q;

      if (tick_q) begin
         if (any_press)
            idle_d = '0;
         else if (state_q != ST_RUN)
            idle_d = idle_step;
      end

      if (mode_press) begin
         // Mode wins over any up/down event in the same tick.
         state_d = next_mode_state(state_q);
      end else if (timeout) begin
         state_d = ST_RUN;
         idle_d  = '0;
      end else begin
         case (state_q)
            ST_SET_HR, ST_SET_MIN: begin
               if (up_ev && !dn_ev)
                  inc_d = 1'b1;
               else if (dn_ev && !up_ev)
                  dec_d = 1'b1;
            end
            ST_SET_SEC: begin
               clr_d = up_press | dn_press;
            end
            default: ;
         endcase
      end
   end

   // Blink restarts in the visible phase on every entry into a SET state.
   always_comb begin
      blink_d = blink_q;
      bcnt_d  = bcnt_q;
      if (state_d == ST_RUN) begin
         blink_d = 1'b0;
         bcnt_d  = '0;
      end else if (state_d != state_q) begin
         blink_d = 1'b1;
         bcnt_d  = '0;
      end else if (tick_q) begin
         if (bcnt_step == BLINK_MAX) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
         end else begin
            bcnt_d = bcnt_step;
         end
      end
   end

   assign run_en    = run_en_q;
   assign field_sel = fsel_q;
   assign inc_pulse = inc_q;
   assign dec_pulse = dec_q;
   assign clr_pulse = clr_q;
   assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

   logic       clk_in   = 1'b0;
   logic       reset    = 1'b1;
   logic       tick_in  = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up   = 1'b0;
   logic       btn_down = 1'b0;
   logic       run_en;
   logic [1:0] field_sel;
   logic       inc_pulse, dec_pulse, clr_pulse, blink;

   localparam int K_STATE = 0;
   localparam int K_INC   = 1;
   localparam int K_DEC   = 2;
   localparam int K_CLR   = 3;

   clock_set_ctrl #(
      .REPEAT_DELAY(50), .REPEAT_RATE(10), .IDLE_TIMEOUT(1000), .BLINK_TICKS(25)
   ) dut (
      .clk_in(clk_in), .reset(reset), .tick_in(tick_in),
      .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .run_en(run_en), .field_sel(field_sel),
      .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .clr_pulse(clr_pulse),
      .blink(blink)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      int         kind;
      logic [1:0] fsel;
      logic       run;
      int         at;
   } ev_t;

   ev_t sb[$];
   ev_t staged[$];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [1:0] fsel, input logic run);
      ev_t e;
      e.kind = kind;
      e.fsel = fsel;
      e.run  = run;
      e.at   = 0;
      staged.push_back(e);
   endtask

   // One slow tick, four clk_in cycles long. Anything staged is due to show up
   // two clock edges after the tick is sampled.
   task automatic tick(input logic m, input logic u, input logic d);
      @(negedge clk_in);
      btn_mode = m;
      btn_up   = u;
      btn_down = d;
      tick_in  = 1'b1;
      while (staged.size() > 0) begin
         ev_t e;
         e = staged.pop_front();
         e.at = cyc + 2;
         sb.push_back(e);
      end
      @(negedge clk_in);
      tick_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
   endtask

   // Monitor: any pulse or change of run_en/field_sel is an output event.
   logic [1:0] prev_fsel;
   logic       prev_run;
   always @(negedge clk_in) begin : monitor
      int  np;
      int  kind;
      ev_t e;
      if (reset) begin
         prev_fsel = field_sel;
         prev_run  = run_en;
      end else begin
         np = int'(inc_pulse) + int'(dec_pulse) + int'(clr_pulse);
         if (np > 0 || field_sel != prev_fsel || run_en != prev_run) begin
            kind = inc_pulse ? K_INC : dec_pulse ? K_DEC : clr_pulse ? K_CLR : K_STATE;
            if (np > 0) check("one_pulse_max", np, 1);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: kind %0d fsel %0d run %0d at cycle %0d, expected none",
                        kind, field_sel, run_en, cyc);
            end else begin
               e = sb.pop_front();
               check("ev_kind", kind, e.kind);
               check("ev_fsel", int'(field_sel), int'(e.fsel));
               check("ev_run", int'(run_en), int'(e.run));
               check("ev_cycle", cyc, e.at);
            end
         end
         prev_fsel = field_sel;
         prev_run  = run_en;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_run_en"}, int'(run_en), 1);
      check({tag, "_fsel"}, int'(field_sel), 3);
      check({tag, "_inc"}, int'(inc_pulse), 0);
      check({tag, "_dec"}, int'(dec_pulse), 0);
      check({tag, "_clr"}, int'(clr_pulse), 0);
      check({tag, "_blink"}, int'(blink), 0);
   endtask

   initial begin : stim
      // Power-on reset
      repeat (3) @(posedge clk_in);
      #1;
      check_idle_outputs("por");
      @(posedge clk_in);
      #1 reset = 1'b0;

      // Four mode presses through the whole cycle
      expect_ev(K_STATE, 2'b00, 1'b0); tick(1, 0, 0);
      check("blink_enter_hr", int'(blink), 1);
      tick(0, 0, 0);
      expect_ev(K_STATE, 2'b01, 1'b0); tick(1, 0, 0); tick(0, 0, 0);
      expect_ev(K_STATE, 2'b10, 1'b0); tick(1, 0, 0); tick(0, 0, 0);
      expect_ev(K_STATE, 2'b11, 1'b1); tick(1, 0, 0);
      check("blink_run", int'(blink), 0);
      tick(0, 0, 0);

      // SET_HR: tap up, tap down
      expect_ev(K_STATE, 2'b00, 1'b0); tick(1, 0, 0); tick(0, 0, 0);
      expect_ev(K_INC, 2'b00, 1'b0); tick(0, 1, 0); tick(0, 0, 0);
      expect_ev(K_DEC, 2'b00, 1'b0); tick(0, 0, 1); tick(0, 0, 0);

      // Up and down together: nothing
      tick(0, 1, 1); tick(0, 0, 0);

      // Mode with up: advance only
      expect_ev(K_STATE, 2'b01, 1'b0); tick(1, 1, 0); tick(0, 0, 0);

      // SET_MIN: hold up for ticks 0..80
      for (int k = 0; k <= 80; k++) begin
         if (k == 0 || k == 50 || k == 60 || k == 70 || k == 80)
            expect_ev(K_INC, 2'b01, 1'b0);
         tick(0, 1, 0);
      end
      tick(0, 0, 0);

      // SET_SEC: hold up 80 ticks, one clear only
      expect_ev(K_STATE, 2'b10, 1'b0); tick(1, 0, 0); tick(0, 0, 0);
      for (int k = 0; k < 80; k++) begin
         if (k == 0) expect_ev(K_CLR, 2'b10, 1'b0);
         tick(0, 1, 0);
      end
      tick(0, 0, 0);

      // Back to RUN; up press ignored
      expect_ev(K_STATE, 2'b11, 1'b1); tick(1, 0, 0); tick(0, 0, 0);
      tick(0, 1, 0); tick(0, 0, 0);
      check("run_after_up", int'(run_en), 1);

      // Blink phase and idle timeout from SET_HR
      expect_ev(K_STATE, 2'b00, 1'b0); tick(1, 0, 0);
      for (int k = 1; k <= 1000; k++) begin
         if (k == 1000) expect_ev(K_STATE, 2'b11, 1'b1);
         tick(0, 0, 0);
         if (k == 24) check("blink_tick24", int'(blink), 1);
         if (k == 25) check("blink_tick25", int'(blink), 0);
         if (k == 50) check("blink_tick50", int'(blink), 1);
      end
      check("timeout_run_en", int'(run_en), 1);
      check("timeout_blink", int'(blink), 0);

      // Press at tick 999 restarts the idle count
      expect_ev(K_STATE, 2'b00, 1'b0); tick(1, 0, 0);
      for (int k = 1; k <= 1999; k++) begin
         if (k == 999)  expect_ev(K_INC, 2'b00, 1'b0);
         if (k == 1999) expect_ev(K_STATE, 2'b11, 1'b1);
         tick(0, (k == 999), 0);
         if (k == 1000) check("no_timeout_1000", int'(run_en), 0);
      end

      // Reset in SET_MIN while up is held
      expect_ev(K_STATE, 2'b00, 1'b0); tick(1, 0, 0); tick(0, 0, 0);
      expect_ev(K_STATE, 2'b01, 1'b0); tick(1, 0, 0); tick(0, 0, 0);
      expect_ev(K_INC, 2'b01, 1'b0); tick(0, 1, 0);
      tick(0, 1, 0); tick(0, 1, 0);
      @(posedge clk_in);
      #1 reset = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      repeat (2) @(posedge clk_in);
      #1 reset = 1'b0;
      tick(0, 1, 0); tick(0, 0, 0);
      tick(0, 1, 0); tick(0, 0, 0);
      check("post_reset_run", int'(run_en), 1);
      check("post_reset_fsel", int'(field_sel), 3);

      repeat (6) @(negedge clk_in);
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller for the digital clock. Samples the mode/up/down push-buttons on the slow tick, detects presses with the same two-flop rising-edge scheme as the debouncer, and drives a RUN/SET_HR/SET_MIN/SET_SEC state machine. Outputs are single-cycle adjust pulses, a field select, a run enable and a blink flag, consumed by the hh:mm:ss counters and the display mux. Holding up or down auto-repeats.

## Interface
- REPEAT_DELAY, 50: ticks a button is held before auto-repeat starts
- REPEAT_RATE, 10: ticks between auto-repeat pulses
- IDLE_TIMEOUT, 1000: ticks without a press before a SET state returns to RUN
- BLINK_TICKS, 25: ticks per blink half-period
- clk_in  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-high reset
- tick_in  input  1  one-clk_in-cycle enable from the slow-clock divider
- btn_mode  input  1  mode button level
- btn_up  input  1  up button level
- btn_down  input  1  down button level
- run_en  output  1  timekeeping counters may advance
- field_sel  output  2  field being set: 00 hr, 01 min, 10 sec, 11 none (RUN)
- inc_pulse  output  1  increment selected field (wraps in datapath)
- dec_pulse  output  1  decrement selected field
- clr_pulse  output  1  clear seconds
- blink  output  1  blank the selected display field when high

## Operation
- Per button, on each tick: s1<=btn, s2<=s1. A press event is s1&~s2, evaluated in the cycle after the tick only.
- States: RUN(0), SET_HR(1), SET_MIN(2), SET_SEC(3).
- A mode press advances the state RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- In SET_HR/SET_MIN:
  - An up press gives inc_pulse; a down press gives dec_pulse.
  - Up and down press events in the same tick are both ignored.
- In SET_SEC, an up or down press gives clr_pulse. There is no auto-repeat in this state.
- In RUN, up and down presses are ignored.
- A mode press in the same tick as up or down: the state advances and up/down are ignored.
- Auto-repeat:
  - The hold counter is 0 on the press tick and increments each tick while s1 stays high. It saturates at REPEAT_DELAY+REPEAT_RATE, re-arming to REPEAT_DELAY after each repeat.
  - A repeat pulse fires when the count equals REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, and so on.
  - The counter clears when s1 is low.
  - If both up and down are held, there is no repeat.
- Idle counter:
  - Counts ticks in SET states and clears on any press event.
  - On reaching IDLE_TIMEOUT, the state goes to RUN and the counter clears.
- run_en is 1 only in RUN; the time is frozen while setting.
- field_sel is the state minus 1, or 11 in RUN.
- blink:
  - 0 in RUN.
  - Set to 1 on entry to any SET state.
  - Toggles every BLINK_TICKS ticks.
- Reset (any time, including mid-SET):
  - State RUN, run_en=1, field_sel=11.
  - All pulses 0, blink=0.
  - All s1/s2/hold/idle/blink counters 0.

## Timing
- Button level captured at the tick in cycle T gives the press event in T+1. State and outputs update registered, visible in T+2.
- inc/dec/clr pulses are high for exactly one clk_in cycle per event. At most one of them is high in any cycle.
- run_en and field_sel change in the same cycle as the state.
- The timeout transition is visible 2 cycles after the IDLE_TIMEOUT-th tick.
- The mode button has no auto-repeat; holding it gives one advance.
- All counter widths are $clog2(param+1).

## Structure
- Package clock_ctrl_pkg holds:
  - the state encoding (RUN/SET_HR/SET_MIN/SET_SEC);
  - the field_sel codes (FLD_HR, FLD_MIN, FLD_SEC, FLD_NONE).
- Sub-module btn_sampler, instantiated three times, holds the tick-gated s1/s2 flops, the press-event output, the hold counter and the repeat-event output. It takes REPEAT_DELAY and REPEAT_RATE as parameters.
- The top level holds the FSM, the idle and blink counters, and the output registers.

## Test plan
- Reset asserted while in SET_MIN with btn_up held: immediately state RUN, run_en=1, field_sel=11, pulses 0. After release, a new up press in RUN gives no pulse.
- Four mode presses: field_sel reads 00, 01, 10, 11 and run_en reads 0, 0, 0, 1, each visible 2 cycles after the pressing tick.
- In SET_HR, tap up once, then down once: one inc_pulse and one dec_pulse, each exactly 1 cycle wide, field_sel=00.
- In SET_MIN, hold up for ticks 0..80 with DELAY=50, RATE=10: exactly 5 inc_pulses, at ticks 0, 50, 60, 70, 80. In SET_SEC, hold up 80 ticks: exactly 1 clr_pulse.
- Enter SET_HR, then no press for 1000 ticks: RUN at tick 1000, run_en=1, blink=0. A press at tick 999 restarts the count instead.
- Simultaneous cases:
  - up and down rising on the same tick in SET_HR: no pulse;
  - mode and up on the same tick in SET_HR: advance to SET_MIN, no inc_pulse.
